dkong_vram_arbiter: RTL and testbench

Single-port VRAM arbiter for the dkong video subsystem. It shares one synchronous-read tile/object VRAM between the Z80 bus, which does CPU reads and writes, and the video tile/object fetch pipeline. Video fetches have absolute priority. CPU accesses run one per bus cycle, in gaps between fetches, and `vram_busy` stalls the CPU until its access is served. One instance sits in front of each VRAM bank.

---
 rtl/dkong_video_pkg.sv | 21 ++
 rtl/dkong_vram_arbiter_if.sv | 42 ++++
 rtl/dkong_cpu_cycle_detect.sv | 37 +++
 rtl/dkong_vram_arbiter.sv | 129 ++++++++++++
 tb/tb_dkong_vram_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dkong_video_pkg.sv
// Shared types for the dkong video subsystem: VRAM arbiter state and the
// latched CPU request slot.
package dkong_video_pkg;

  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    CPU_RD   = 2'd2,
    CPU_DONE = 2'd3
  } vram_arb_state_t;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] wdata;
    logic                   is_write;
  } vram_cpu_req_t;

endpackage

// File: rtl/dkong_vram_arbiter_if.sv
// Bundle of the Z80 bus, video fetch and VRAM port signals around one arbiter.
interface dkong_vram_arbiter_if
  import dkong_video_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) ();

  logic              cpu_sel;
  logic              cpu_rdn;
  logic              cpu_wrn;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vram_busy;
  logic              fetch_window;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // CPU, video pipeline and RAM side.
  modport master (
    output cpu_sel, cpu_rdn, cpu_wrn, cpu_addr, cpu_wdata,
    output fetch_window, vid_req, vid_addr, ram_rdata,
    input  cpu_rdata, vram_busy, vid_valid, vid_rdata,
    input  ram_addr, ram_we, ram_wdata
  );

  // Arbiter side.
  modport slave (
    input  cpu_sel, cpu_rdn, cpu_wrn, cpu_addr, cpu_wdata,
    input  fetch_window, vid_req, vid_addr, ram_rdata,
    output cpu_rdata, vram_busy, vid_valid, vid_rdata,
    output ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/dkong_cpu_cycle_detect.sv
// Z80 bus cycle framing: one start pulse per strobe assertion and one end
// pulse when the bus goes idle again.
module dkong_cpu_cycle_detect (
  input  logic clk,
  input  logic rst,
  input  logic cpu_sel,
  input  logic cpu_rdn,
  input  logic cpu_wrn,
  output logic cyc_start,
  output logic cyc_end,
  output logic cyc_active,
  output logic cyc_is_write
);

  logic in_cycle_reg;
  logic strobe_one;
  logic bus_idle;

  // Both strobes low is a glitch state and neither starts nor ends a cycle.
  assign strobe_one   = cpu_sel & (cpu_rdn ^ cpu_wrn);
  assign bus_idle     = ~cpu_sel | (cpu_rdn & cpu_wrn);
  assign cyc_start    = strobe_one & ~in_cycle_reg;
  assign cyc_end      = in_cycle_reg & bus_idle;
  assign cyc_active   = in_cycle_reg;
  assign cyc_is_write = ~cpu_wrn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cycle_reg <= 1'b0;
    end else if (cyc_start) begin
      in_cycle_reg <= 1'b1;
    end else if (cyc_end) begin
      in_cycle_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/dkong_vram_arbiter.sv
// Single-port VRAM arbiter: video fetches win every cycle, CPU accesses are
// latched and issued once per bus cycle in the gaps.
module dkong_vram_arbiter
  import dkong_video_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input logic                 clk,
  input logic                 rst,
  dkong_vram_arbiter_if.slave bus
);

  vram_arb_state_t   state_reg, state_next;
  vram_cpu_req_t     req_reg, req_next;
  logic              pending_reg, pending_next;
  logic              busy_reg, busy_next;
  logic              vid_valid_reg;
  logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
  logic [DATA_W-1:0] vid_rdata_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_wdata_reg;

  logic              cyc_start, cyc_end, cyc_active, cyc_is_write;
  logic              vid_grant, cpu_issue, accept;
  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_we_c;
  logic [DATA_W-1:0] ram_wdata_c;

  dkong_cpu_cycle_detect u_cycle_detect (
    .clk          (clk),
    .rst          (rst),
    .cpu_sel      (bus.cpu_sel),
    .cpu_rdn      (bus.cpu_rdn),
    .cpu_wrn      (bus.cpu_wrn),
    .cyc_start    (cyc_start),
    .cyc_end      (cyc_end),
    .cyc_active   (cyc_active),
    .cyc_is_write (cyc_is_write)
  );

  // Reset gates the grant so the RAM port shows its reset values at once.
  assign vid_grant = bus.vid_req & ~rst;
  assign cpu_issue = (state_reg == CPU_ACC) & ~vid_grant;
  assign accept    = cyc_start & ~pending_reg &
                     ((state_reg == IDLE) | (state_reg == CPU_DONE));

  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg;
    req_next       = req_reg;
    cpu_rdata_next = cpu_rdata_reg;

    if (accept) begin
      pending_next      = 1'b1;
      req_next.addr     = bus.cpu_addr;
      req_next.wdata    = bus.cpu_wdata;
      req_next.is_write = cyc_is_write;
    end

    case (state_reg)
      IDLE: begin
        if (accept) state_next = CPU_ACC;
      end
      CPU_ACC: begin
        if (cpu_issue) begin
          if (req_reg.is_write) begin
            state_next   = CPU_DONE;
            pending_next = 1'b0;
          end else begin
            state_next = CPU_RD;
          end
        end
      end
      CPU_RD: begin
        cpu_rdata_next = bus.ram_rdata;
        state_next     = CPU_DONE;
        pending_next   = 1'b0;
      end
      CPU_DONE: begin
        // A start seen here means the CPU already closed the previous cycle.
        if (accept) state_next = CPU_ACC;
        else if (cyc_end | ~cyc_active) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = bus.fetch_window | (pending_next & (state_next != CPU_DONE));

  assign ram_addr_c  = vid_grant ? bus.vid_addr :
                       (cpu_issue ? req_reg.addr : ram_addr_reg);
  assign ram_we_c    = cpu_issue & req_reg.is_write;
  assign ram_wdata_c = ram_we_c ? req_reg.wdata : ram_wdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pending_reg   <= 1'b0;
      req_reg       <= '0;
      busy_reg      <= 1'b0;
      vid_valid_reg <= 1'b0;
      cpu_rdata_reg <= '0;
      vid_rdata_reg <= '0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      req_reg       <= req_next;
      busy_reg      <= busy_next;
      vid_valid_reg <= vid_grant;
      cpu_rdata_reg <= cpu_rdata_next;
      ram_addr_reg  <= ram_addr_c;
      ram_wdata_reg <= ram_wdata_c;
      if (vid_valid_reg) vid_rdata_reg <= bus.ram_rdata;
    end
  end

  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.vram_busy = busy_reg;
  assign bus.vid_valid = vid_valid_reg;
  // RAM data passes straight through on the valid cycle and is held after.
  assign bus.vid_rdata = vid_valid_reg ? bus.ram_rdata : vid_rdata_reg;

endmodule

// File: tb/tb_dkong_vram_arbiter.sv
// Randomized bench for dkong_vram_arbiter against a cycle-level access model
// and a reference copy of the VRAM contents.
module tb_dkong_vram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dkong_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dkong_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External synchronous-read VRAM.
  logic [7:0] ram_mem [0:1023];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  logic [7:0] ref_mem [0:1023];
  int         tests_run    = 0;
  int         tests_failed = 0;
  bit         prev_vid     = 1'b0;
  bit         fw_prev      = 1'b0;
  logic [7:0] exp_vid_data = 8'h00;
  logic [7:0] exp_cpu_rdata = 8'h00;
  logic [7:0] old_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle(input bit fw);
    bus.cpu_sel      = 1'b0;
    bus.cpu_rdn      = 1'b1;
    bus.cpu_wrn      = 1'b1;
    bus.vid_req      = 1'b0;
    bus.fetch_window = fw;
    @(negedge clk);
    check_eq("idle_busy", bus.vram_busy, fw_prev);
    check_eq("idle_vvalid", bus.vid_valid, prev_vid);
    if (prev_vid) check_eq("idle_vdata", bus.vid_rdata, exp_vid_data);
    check_eq("idle_we", bus.ram_we, 0);
    check_eq("idle_rdata", bus.cpu_rdata, exp_cpu_rdata);
    prev_vid = 1'b0;
    fw_prev  = fw;
    @(posedge clk);
    #1;
  endtask

  // vid_mode: 0 none, 1 vid_req for the first vid_n cycles, 2 random 50%.
  task automatic cpu_access(input bit is_wr, input logic [9:0] addr, input logic [7:0] wdata,
                            input int vid_mode, input int vid_n, input int hold, input bit fw);
    int         k;
    int         c;
    bit         vid;
    bit         done;
    bit         committed;
    logic [9:0] va;
    k = 0; c = -1; done = 1'b0; committed = 1'b0;
    bus.cpu_sel      = 1'b1;
    bus.cpu_rdn      = is_wr;
    bus.cpu_wrn      = !is_wr;
    bus.cpu_addr     = addr;
    bus.cpu_wdata    = wdata;
    bus.fetch_window = fw;
    while (k < 200) begin
      case (vid_mode)
        0:       vid = 1'b0;
        1:       vid = (k < vid_n);
        default: vid = ($urandom_range(0, 1) == 1);
      endcase
      va = 10'($urandom_range(0, 1023));
      bus.vid_req  = vid;
      bus.vid_addr = va;
      // The CPU issues on the first cycle after the start with no video request.
      if (!committed && k >= 1 && !vid) begin
        committed = 1'b1;
        c = k;
      end
      @(negedge clk);
      check_eq("ram_we", bus.ram_we, (is_wr && k == c));
      if (vid) begin
        check_eq("vid_ram_addr", bus.ram_addr, va);
      end else if (k == c) begin
        check_eq("cpu_ram_addr", bus.ram_addr, addr);
        if (is_wr) check_eq("cpu_ram_wdata", bus.ram_wdata, wdata);
      end
      check_eq("vid_valid", bus.vid_valid, prev_vid);
      if (prev_vid) check_eq("vid_rdata", bus.vid_rdata, exp_vid_data);
      if (k >= 1) check_eq("busy", bus.vram_busy, (fw | !done));
      else        check_eq("busy_start", bus.vram_busy, fw_prev);
      check_eq("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
      if (vid) exp_vid_data = ref_mem[va];
      prev_vid = vid;
      fw_prev  = fw;
      if (is_wr && k == c) begin
        ref_mem[addr] = wdata;
        done = 1'b1;
      end
      if (!is_wr && committed && k == c + 1) begin
        exp_cpu_rdata = ref_mem[addr];
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      k++;
      if (done && k > hold) break;
    end
    check_eq("access_done", done, 1);
    $display("[TB] %s addr=%03h data=%02h issue=+%0d cycles=%0d",
             is_wr ? "WR" : "RD", addr, is_wr ? wdata : exp_cpu_rdata, c, k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      old_val    = 8'($urandom_range(0, 255));
      ram_mem[i] = old_val;
      ref_mem[i] = old_val;
    end
    rst              = 1'b1;
    bus.cpu_sel      = 1'b0;
    bus.cpu_rdn      = 1'b1;
    bus.cpu_wrn      = 1'b1;
    bus.cpu_addr     = '0;
    bus.cpu_wdata    = '0;
    bus.fetch_window = 1'b0;
    bus.vid_req      = 1'b0;
    bus.vid_addr     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cpu_rdata", bus.cpu_rdata, 0);
    check_eq("rst_busy", bus.vram_busy, 0);
    check_eq("rst_vid_valid", bus.vid_valid, 0);
    check_eq("rst_vid_rdata", bus.vid_rdata, 0);
    check_eq("rst_ram_addr", bus.ram_addr, 0);
    check_eq("rst_ram_we", bus.ram_we, 0);
    check_eq("rst_ram_wdata", bus.ram_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle(1'b0);

    // Write then read back, quiet video.
    cpu_access(1'b1, 10'h123, 8'hA5, 0, 0, 0, 1'b0);
    drive_idle(1'b0);
    cpu_access(1'b0, 10'h123, 8'h00, 0, 0, 0, 1'b0);
    drive_idle(1'b0);

    // Write held off by ten back-to-back fetches, including one at the start.
    cpu_access(1'b1, 10'h3FF, 8'h3C, 1, 10, 0, 1'b0);
    drive_idle(1'b0);
    cpu_access(1'b0, 10'h3FF, 8'h00, 1, 4, 0, 1'b0);
    drive_idle(1'b0);

    // Strobe held for 20 cycles: one write only.
    cpu_access(1'b1, 10'h0F0, 8'h77, 0, 0, 20, 1'b0);
    drive_idle(1'b0);

    // fetch_window raises busy ahead of a start but does not block issue.
    drive_idle(1'b1);
    drive_idle(1'b1);
    cpu_access(1'b1, 10'h2AA, 8'h5C, 0, 0, 0, 1'b1);
    drive_idle(1'b1);
    drive_idle(1'b0);
    drive_idle(1'b0);

    // Reset while a write sits blocked in CPU_ACC.
    old_val          = ref_mem[10'h055];
    bus.cpu_sel      = 1'b1;
    bus.cpu_rdn      = 1'b1;
    bus.cpu_wrn      = 1'b0;
    bus.cpu_addr     = 10'h055;
    bus.cpu_wdata    = ~old_val;
    bus.vid_req      = 1'b1;
    bus.vid_addr     = 10'h200;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("pre_rst_busy", bus.vram_busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", bus.vram_busy, 0);
    check_eq("mid_rst_vid_valid", bus.vid_valid, 0);
    check_eq("mid_rst_vid_rdata", bus.vid_rdata, 0);
    check_eq("mid_rst_ram_we", bus.ram_we, 0);
    check_eq("mid_rst_ram_addr", bus.ram_addr, 0);
    check_eq("mid_rst_ram_wdata", bus.ram_wdata, 0);
    check_eq("mid_rst_cpu_rdata", bus.cpu_rdata, 0);
    bus.cpu_sel = 1'b0;
    bus.cpu_wrn = 1'b1;
    bus.vid_req = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    prev_vid      = 1'b0;
    fw_prev       = 1'b0;
    exp_cpu_rdata = 8'h00;
    $display("[TB] RST abandoned write addr=055");
    drive_idle(1'b0);
    cpu_access(1'b0, 10'h055, 8'h00, 0, 0, 0, 1'b0);
    drive_idle(1'b0);
    check_eq("rst_no_write", exp_cpu_rdata, old_val);

    // Bulk load and readback under 50% random video traffic.
    for (int i = 0; i < 1024; i++) begin
      cpu_access(1'b1, 10'(i), 8'(i & 8'hFF), 2, 0, 0, 1'b0);
      drive_idle(1'b0);
    end
    for (int i = 0; i < 1024; i++) begin
      cpu_access(1'b0, 10'(i), 8'h00, 2, 0, 0, 1'b0);
      drive_idle(1'b0);
      check_eq("bulk_readback", bus.cpu_rdata, 8'(i & 8'hFF));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
